// File: rtl/frame_row_reader.sv
// Read-side sequencer for the frame row RAM: scans rows 0..NUM_ROWS-1 and streams them over valid/ready.
// Build option: define READER_LOOP_EN for continuous frame replay (no DRAIN/DONE, rd_ptr wraps to 0).
module frame_row_reader #(
  parameter int unsigned ROW_W    = 640,
  parameter int unsigned NUM_ROWS = 480,
  parameter int unsigned ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ram_full,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [ROW_W-1:0]  ram_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_row,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  logic [2:0]        state, state_next;
  logic [ADDR_W-1:0] rd_ptr;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_row;

  // Second FIFO entry; the out_* registers act as the FIFO head.
  logic              sk_valid;
  logic [ROW_W-1:0]  sk_data;
  logic [ADDR_W-1:0] sk_row;
  logic              sk_sof;
  logic              sk_eof;

  logic              pop_c;
  logic              issue_c;
  logic              last_issue_c;
  logic [1:0]        occ_c;
  logic              cap_sof_c;
  logic              cap_eof_c;

  assign ram_addr     = rd_ptr;
  assign pop_c        = out_valid & out_ready;
  assign occ_c        = 2'(out_valid) + 2'(sk_valid) + 2'(inflight);
  // Credit check counts the in-flight read so the 2-entry FIFO can never overflow.
  assign issue_c      = (state == ST_SCAN) && ({1'b0, occ_c} < (3'd2 + 3'(pop_c)));
  assign last_issue_c = issue_c && (rd_ptr == LAST_ROW);
  assign cap_sof_c    = (inflight_row == '0);
  assign cap_eof_c    = (inflight_row == LAST_ROW);

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_WAIT;
      ST_WAIT:  if (ram_full) state_next = ST_SCAN;
      ST_SCAN: begin
`ifdef READER_LOOP_EN
        state_next = ST_SCAN;
`else
        if (last_issue_c) state_next = ST_DRAIN;
`endif
      end
      ST_DRAIN: if (!out_valid && !sk_valid && !inflight) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, issue tracking and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rd_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_row <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != ST_IDLE);
      done     <= (state_next == ST_DONE);
      inflight <= issue_c;
      if (issue_c) begin
        inflight_row <= rd_ptr;
        rd_ptr       <= last_issue_c ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  // Output FIFO: head in out_* registers, overflow entry in sk_*
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      sk_row    <= '0;
      sk_sof    <= 1'b0;
      sk_eof    <= 1'b0;
    end else begin
      if (pop_c) begin
        if (sk_valid) begin
          out_data <= sk_data;
          out_row  <= sk_row;
          out_sof  <= sk_sof;
          out_eof  <= sk_eof;
          sk_valid <= inflight;
          if (inflight) begin
            sk_data <= ram_data;
            sk_row  <= inflight_row;
            sk_sof  <= cap_sof_c;
            sk_eof  <= cap_eof_c;
          end
        end else begin
          out_valid <= inflight;
          if (inflight) begin
            out_data <= ram_data;
            out_row  <= inflight_row;
            out_sof  <= cap_sof_c;
            out_eof  <= cap_eof_c;
          end
        end
      end else if (inflight) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= ram_data;
          out_row   <= inflight_row;
          out_sof   <= cap_sof_c;
          out_eof   <= cap_eof_c;
        end else begin
          sk_valid <= 1'b1;
          sk_data  <= ram_data;
          sk_row   <= inflight_row;
          sk_sof   <= cap_sof_c;
          sk_eof   <= cap_eof_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_row_reader.sv
// Self-checking bench for frame_row_reader: table-driven startup/latency vectors plus streaming,
// backpressure and mid-frame reset sequences against a behavioural RAM and row scoreboard.
module tb_frame_row_reader;

  localparam int unsigned ROW_W    = 640;
  localparam int unsigned NUM_ROWS = 480;
  localparam int unsigned ADDR_W   = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              ram_full;
  logic [ADDR_W-1:0] ram_addr;
  logic [ROW_W-1:0]  ram_data;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_row;
  logic              out_sof;
  logic              out_eof;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  frame_row_reader #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .ram_full(ram_full), .ram_addr(ram_addr),
    .ram_data(ram_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [ROW_W-1:0] pat(input int r);
    logic [ROW_W-1:0] v;
    for (int i = 0; i < int'(ROW_W / 32); i++)
      v[i*32 +: 32] = (32'(r) * 32'h9E3779B1) ^ (32'(i) << 20) ^ 32'h00A5_5A00;
    return v;
  endfunction

  // Registered-read RAM model: one cycle from address to data
  always @(posedge clk) ram_data <= pat(int'(ram_addr));

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1; ram_full = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Streams max_beats rows with out_ready high, optionally stalling at one row.
  task automatic stream(input int max_beats, input int stall_row, input int stall_len, input bit check_tput);
    int beats = 0;
    int cyc = 0;
    int first = -1;
    int last = 0;
    bit stalled = 1'b0;
    out_ready = 1'b1;
    while (beats < max_beats && cyc < max_beats * 4 + 200) begin
      if (out_valid) begin
        if (!stalled && stall_len > 0 && beats == stall_row) begin
          stalled = 1'b1;
          out_ready = 1'b0;
          for (int k = 0; k < stall_len; k++) begin
            step(); cyc++;
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_row", 32'(out_row), stall_row);
            chk_data("stall_data", out_data, pat(stall_row));
          end
          out_ready = 1'b1;
        end
        chk("beat_row", 32'(out_row), beats % NUM_ROWS);
        chk_data("beat_data", out_data, pat(beats % NUM_ROWS));
        chk("beat_sof", 32'(out_sof), (beats % NUM_ROWS) == 0 ? 1 : 0);
        chk("beat_eof", 32'(out_eof), (beats % NUM_ROWS) == NUM_ROWS - 1 ? 1 : 0);
        if (first < 0) first = cyc;
        last = cyc;
        beats++;
      end
      step(); cyc++;
    end
    chk("stream_beats", beats, max_beats);
    if (check_tput) chk("throughput_span", last - first, max_beats - 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      step(); n++;
    end
    chk("done_seen", 32'(done), 1);
    step();
    chk("done_single_cycle", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  typedef struct {
    logic start;
    logic full;
    logic ready;
    logic exp_busy;
    logic exp_valid;
    int   exp_row;
    logic exp_sof;
  } vec_t;

  vec_t tbl[15];
  int   d0;

  initial begin
    // start with ram_full low for 10 cycles, then raise it: row 0 appears on the 3rd edge
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    for (int i = 1; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1};

    rst = 1'b1; start = 1'b0; ram_full = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_row", 32'(out_row), 0);
    chk_data("rst_data", out_data, '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      start = tbl[i].start; ram_full = tbl[i].full; out_ready = tbl[i].ready;
      step();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d_row", i), 32'(out_row), tbl[i].exp_row);
        chk($sformatf("vec%0d_sof", i), 32'(out_sof), 32'(tbl[i].exp_sof));
        chk_data($sformatf("vec%0d_data", i), out_data, pat(tbl[i].exp_row));
      end
    end
    start = 1'b0;
    ram_full = 1'b1;

`ifdef READER_LOOP_EN
    // Continuous replay: rows wrap 479 -> 0 with sof, done never pulses
    stream(1000, -1, 0, 1'b1);
    chk("loop_done_count", done_cnt, 0);
    chk("loop_busy", 32'(busy), 1);
`else
    // Frame 1: backpressure at row 100 for 20 cycles
    d0 = done_cnt;
    stream(NUM_ROWS, 100, 20, 1'b0);
    wait_done();
    chk("frame1_done_count", done_cnt - d0, 1);

    // Frame 2: full rate, one beat per clock
    d0 = done_cnt;
    start_frame();
    stream(NUM_ROWS, -1, 0, 1'b1);
    wait_done();
    chk("frame2_done_count", done_cnt - d0, 1);

    // Frame 3: reset while row 200 is presented, then rescan from row 0
    d0 = done_cnt;
    start_frame();
    stream(200, -1, 0, 1'b0);
    chk("abort_valid_before", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_addr", 32'(ram_addr), 0);
    chk("abort_row", 32'(out_row), 0);
    chk("abort_sof", 32'(out_sof), 0);
    chk_data("abort_data", out_data, '0);
    rst = 1'b0;
    repeat (3) step();
    chk("abort_no_done", done_cnt - d0, 0);
    start_frame();
    stream(NUM_ROWS, -1, 0, 1'b1);
    wait_done();
    chk("frame3_done_count", done_cnt - d0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
